// File: rtl/clock_reset_sequencer.sv
// Lock-qualified staggered reset release with per-channel clock-enable dividers.
// Optional CLOCK_RESET_SEQ_SOFT_RESET_EN adds iSOFT_RESET, a synchronous restart equivalent to lock loss.
module clock_reset_sequencer #(
  parameter int P_CHANNELS    = 4,
  parameter int P_DIV_WIDTH   = 8,
  parameter int P_LOCK_STABLE = 256,
  parameter int P_STAGGER     = 16
) (
  input  logic                              iCLOCK,
  input  logic                              inRESET,
  input  logic                              iPLL_LOCK,
`ifdef CLOCK_RESET_SEQ_SOFT_RESET_EN
  input  logic                              iSOFT_RESET,
`endif
  input  logic [P_CHANNELS*P_DIV_WIDTH-1:0] iCH_DIV,
  output logic [P_CHANNELS-1:0]             oRESET_N,
  output logic [P_CHANNELS-1:0]             oCLKEN,
  output logic                              oSYSTEM_READY
);

  localparam int STABLE_W  = $clog2(P_LOCK_STABLE + 1);
  localparam int STAGGER_W = $clog2(P_STAGGER + 1);
  localparam int CH_W      = $clog2(P_CHANNELS + 1);

  localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(P_LOCK_STABLE - 1);
  localparam logic [STABLE_W-1:0]  STABLE_FULL  = STABLE_W'(P_LOCK_STABLE);
  localparam logic [STAGGER_W-1:0] STAGGER_LAST = STAGGER_W'(P_STAGGER - 1);
  localparam logic [CH_W-1:0]      CH_LAST      = CH_W'(P_CHANNELS - 1);
  localparam logic [CH_W-1:0]      CH_ONE       = CH_W'(1);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} seqStateT;

  seqStateT               stateReg, stateNext;
  logic [STABLE_W-1:0]    stableCntReg, stableCntNext;
  logic [STAGGER_W-1:0]   staggerCntReg, staggerCntNext;
  logic [CH_W-1:0]        relCntReg, relCntNext;
  logic [P_CHANNELS-1:0]  resetNReg, resetNNext;
  logic                   readyReg, readyNext;
  logic                   lockMeta, lockSync, lockOk;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      lockMeta <= 1'b0;
      lockSync <= 1'b0;
    end else begin
      lockMeta <= iPLL_LOCK;
      lockSync <= lockMeta;
    end
  end

`ifdef CLOCK_RESET_SEQ_SOFT_RESET_EN
  assign lockOk = lockSync & ~iSOFT_RESET;
`else
  assign lockOk = lockSync;
`endif

  // State register
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stateReg      <= WAIT_LOCK;
      stableCntReg  <= '0;
      staggerCntReg <= '0;
      relCntReg     <= '0;
    end else begin
      stateReg      <= stateNext;
      stableCntReg  <= stableCntNext;
      staggerCntReg <= staggerCntNext;
      relCntReg     <= relCntNext;
    end
  end

  // Next-state logic; relCnt is the number of channels already released.
  always_comb begin
    stateNext      = stateReg;
    stableCntNext  = stableCntReg;
    staggerCntNext = staggerCntReg;
    relCntNext     = relCntReg;
    if (!lockOk) begin
      stateNext      = WAIT_LOCK;
      stableCntNext  = '0;
      staggerCntNext = '0;
      relCntNext     = '0;
    end else begin
      unique case (stateReg)
        WAIT_LOCK, STABLE: begin
          if (stableCntReg == STABLE_LAST) begin
            stableCntNext  = STABLE_FULL;
            staggerCntNext = '0;
            relCntNext     = CH_ONE;
            stateNext      = (P_CHANNELS == 1) ? RUN : RELEASE;
          end else begin
            stableCntNext = stableCntReg + 1'b1;
            stateNext     = STABLE;
          end
        end
        RELEASE: begin
          if (staggerCntReg == STAGGER_LAST) begin
            staggerCntNext = '0;
            relCntNext     = relCntReg + 1'b1;
            if (relCntReg == CH_LAST) stateNext = RUN;
          end else begin
            staggerCntNext = staggerCntReg + 1'b1;
          end
        end
        RUN: stateNext = RUN;
        default: stateNext = WAIT_LOCK;
      endcase
    end
  end

  // Output logic: decoded from next state so every output is a register.
  always_comb begin
    resetNNext = '0;
    for (int k = 0; k < P_CHANNELS; k++) begin
      resetNNext[k] = (int'(relCntNext) > k);
    end
    readyNext = (stateNext == RUN);
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      resetNReg <= '0;
      readyReg  <= 1'b0;
    end else begin
      resetNReg <= resetNNext;
      readyReg  <= readyNext;
    end
  end

  assign oRESET_N      = resetNReg;
  assign oSYSTEM_READY = readyReg;

  genvar gi;
  generate
    for (gi = 0; gi < P_CHANNELS; gi++) begin : gChannel
      logic [P_DIV_WIDTH-1:0] divReg;
      logic [P_DIV_WIDTH-1:0] cntReg;
      logic                   clkenReg;

      // Divide value is captured only on the release edge; counting starts the edge after.
      always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
          divReg   <= '0;
          cntReg   <= '0;
          clkenReg <= 1'b0;
        end else begin
          if (resetNNext[gi] && !resetNReg[gi]) begin
            divReg <= iCH_DIV[gi*P_DIV_WIDTH +: P_DIV_WIDTH];
          end
          if (resetNNext[gi] && resetNReg[gi]) begin
            if (cntReg == divReg) begin
              clkenReg <= 1'b1;
              cntReg   <= '0;
            end else begin
              clkenReg <= 1'b0;
              cntReg   <= cntReg + 1'b1;
            end
          end else begin
            clkenReg <= 1'b0;
            cntReg   <= '0;
          end
        end
      end

      assign oCLKEN[gi] = clkenReg;
    end
  endgenerate

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Randomized bench for clock_reset_sequencer against a run-length based reference model.
module tb_clock_reset_sequencer;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int L  = 256;
  localparam int S  = 16;

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic            pllLock = 1'b0;
  logic [CH*W-1:0] chDiv;
  logic [CH-1:0]   resetN;
  logic [CH-1:0]   clkEn;
  logic            ready;

  always #5 clk = ~clk;

  clock_reset_sequencer #(
    .P_CHANNELS(CH), .P_DIV_WIDTH(W), .P_LOCK_STABLE(L), .P_STAGGER(S)
  ) dut (
    .iCLOCK(clk),
    .inRESET(rstN),
    .iPLL_LOCK(pllLock),
`ifdef CLOCK_RESET_SEQ_SOFT_RESET_EN
    .iSOFT_RESET(1'b0),
`endif
    .iCH_DIV(chDiv),
    .oRESET_N(resetN),
    .oCLKEN(clkEn),
    .oSYSTEM_READY(ready)
  );

  int total = 0;
  int bad = 0;

  // Model: lock history, consecutive synchronized-lock edges, release count.
  int s1 = 0, s2 = 0, run = 0, rel = 0, n = 0;
  int relEdge[CH];
  int dLat[CH];
  bit churn = 1'b0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] randDiv();
    logic [CH*W-1:0] v;
    for (int k = 0; k < CH; k++) begin
      v[k*W +: W] = ($urandom_range(0, 7) == 7) ? 8'hFF : 8'($urandom_range(0, 6));
    end
    return v;
  endfunction

  task automatic modelEdge();
    int lockSeen;
    int prevRel;
    n++;
    if (!rstN) begin
      s1 = 0; s2 = 0; run = 0; rel = 0;
    end else begin
      lockSeen = s2;
      s2 = s1;
      s1 = int'(pllLock);
      run = (lockSeen != 0) ? ((run < 1000000) ? run + 1 : run) : 0;
      prevRel = rel;
      if (run >= L) begin
        rel = 1 + (run - L) / S;
        if (rel > CH) rel = CH;
      end else begin
        rel = 0;
      end
      for (int k = 0; k < CH; k++) begin
        if (k < rel && k >= prevRel) begin
          relEdge[k] = n;
          dLat[k] = int'(chDiv[k*W +: W]);
        end
      end
    end
  endtask

  task automatic checkOutputs();
    logic [31:0] er;
    logic [31:0] ee;
    er = '0;
    ee = '0;
    for (int k = 0; k < CH; k++) begin
      if (k < rel) begin
        er[k] = 1'b1;
        if (n > relEdge[k] && ((n - relEdge[k] - 1) % (dLat[k] + 1)) == dLat[k]) ee[k] = 1'b1;
      end
    end
    checkEq("resetN", 32'(resetN), er);
    checkEq("clken", 32'(clkEn), ee);
    checkEq("ready", 32'(ready), 32'(rel == CH));
  endtask

  task automatic step(input logic lockVal);
    pllLock = lockVal;
    if (churn && $urandom_range(0, 7) == 0) chDiv = randDiv();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic asyncPulse();
    #2 rstN = 1'b0;
    #1;
    s1 = 0; s2 = 0; run = 0; rel = 0;
    checkEq("async_resetN", 32'(resetN), 32'd0);
    checkEq("async_clken", 32'(clkEn), 32'd0);
    checkEq("async_ready", 32'(ready), 32'd0);
    @(negedge clk);
    repeat (3) step(pllLock);
    rstN = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < CH; k++) begin
      relEdge[k] = 0;
      dLat[k] = 0;
    end
    chDiv = {8'd255, 8'd4, 8'd1, 8'd0};
    #12;
    checkEq("rst_resetN", 32'(resetN), 32'd0);
    checkEq("rst_clken", 32'(clkEn), 32'd0);
    checkEq("rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Power-up with D = {0,1,4,255}, then churn iCH_DIV while running.
    repeat (10) step(1'b0);
    repeat (L + CH * S + 10) step(1'b1);
    churn = 1'b1;
    repeat (700) step(1'b1);
    churn = 1'b0;

    // Lock loss in RUN, then a single-cycle glitch at stable count ~200.
    repeat (3) step(1'b0);
    repeat (202) step(1'b1);
    step(1'b0);
    repeat (L + CH * S + 40) step(1'b1);

    // Async reset in the middle of the release sequence.
    repeat (4) step(1'b0);
    repeat (L + 2 + 30) step(1'b1);
    asyncPulse();
    repeat (L + CH * S + 30) step(1'b1);

    // Random lock segments, divide churn and occasional async resets.
    churn = 1'b1;
    for (int seg = 0; seg < 20; seg++) begin
      chDiv = randDiv();
      repeat ($urandom_range(1, 450)) step(1'b1);
      if ($urandom_range(0, 4) == 0) asyncPulse();
      repeat ($urandom_range(1, 4)) step(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_reset_sequencer.md
# clock_reset_sequencer

Parametrised successor to the board-level clock block: it sits beside the system PLL, consumes the PLL lock flag, and releases per-domain resets in a fixed staggered order. It also supplies per-channel clock enables divided from the main clock, so slow logic (VGA pixel, ASMI serial, peripheral ticks) runs from one clock tree. One instance serves the whole board; channel count, divider width and timing are parameters.

## Interface

Parameters:
- P_CHANNELS, 4: number of reset/enable channels (1..16).
- P_DIV_WIDTH, 8: width of each channel's divide value.
- P_LOCK_STABLE, 256: cycles of continuous synchronized lock required before any release (≥1).
- P_STAGGER, 16: cycles between successive channel releases (≥1).

Ports:
- iCLOCK, in, 1: main system clock; only clock in the block.
- inRESET, in, 1: asynchronous, active-low reset. One clock, async active-low reset, as already decided.
- iPLL_LOCK, in, 1: PLL locked flag, asynchronous to iCLOCK.
- iCH_DIV, in, P_CHANNELS*P_DIV_WIDTH: divide value D per channel; channel k uses bits [k*P_DIV_WIDTH +: P_DIV_WIDTH].
- oRESET_N, out, P_CHANNELS: per-channel active-low reset, synchronous to iCLOCK.
- oCLKEN, out, P_CHANNELS: per-channel clock-enable pulse.
- oSYSTEM_READY, out, 1: high when all channels are released.

## Operation

- Lock synchronizer: 2-flop chain on iPLL_LOCK gives lock_s. Only lock_s is used internally.
- FSM states:
  - WAIT_LOCK (reset state): all outputs 0. Goes to STABLE when lock_s=1.
  - STABLE: a stable counter counts cycles with lock_s=1. After P_LOCK_STABLE cycles, goes to RELEASE and releases channel 0.
  - RELEASE: a stagger counter releases channel k+1 P_STAGGER cycles after channel k. Goes to RUN when channel P_CHANNELS-1 is released.
  - RUN: holds until lock loss.
- Lock loss: lock_s=0 in any state other than WAIT_LOCK sends the FSM to WAIT_LOCK and clears all counters. On the next edge, all oRESET_N, oCLKEN and oSYSTEM_READY go to 0.
- Channel release: oRESET_N[k] goes 1 and stays 1 until lock loss or reset. D for channel k is latched from iCH_DIV on the release cycle. Later changes to iCH_DIV are ignored until the channel's next release.
- Divider, per channel: counter c_k, width P_DIV_WIDTH, held at 0 while the channel is in reset.
  - oCLKEN[k]=1 when c_k==D_k, and c_k then returns to 0. Otherwise c_k increments.
  - Result: one pulse every D_k+1 cycles.
  - D_k=0 gives constant 1. D_k=all-ones gives a period of 2^P_DIV_WIDTH cycles with no overflow.
- Counter widths: stable counter $clog2(P_LOCK_STABLE+1) bits, saturating. Stagger counter $clog2(P_STAGGER+1) bits. Channel index $clog2(P_CHANNELS+1) bits.
- oSYSTEM_READY = 1 exactly when the FSM is in RUN, i.e. all oRESET_N bits are 1.

## Timing

- Reset values: oRESET_N=0, oCLKEN=0, oSYSTEM_READY=0, FSM=WAIT_LOCK, all counters 0.
- iPLL_LOCK rise → lock_s rise: 2 cycles.
- lock_s first high at edge T → oRESET_N[0] rises at T+P_LOCK_STABLE.
- oRESET_N[k] rises at T+P_LOCK_STABLE+k*P_STAGGER.
- oSYSTEM_READY rises on the same edge as oRESET_N[P_CHANNELS-1].
- First oCLKEN[k] pulse: D_k+1 cycles after oRESET_N[k] rises; for D_k=0, on the first cycle after release.
- Lock dropping for a single synchronized cycle during STABLE restarts the full P_LOCK_STABLE count.
- iPLL_LOCK fall → all outputs low: 3 cycles (2 sync + 1 register).
- Lock loss on the same edge as a scheduled release: the loss wins and that channel is not released.
- inRESET assertion mid-sequence clears everything immediately (asynchronous). Release of inRESET restarts from WAIT_LOCK.

## Configuration

- CLOCK_RESET_SEQ_SOFT_RESET_EN defined: adds input iSOFT_RESET (1 bit, synchronous, active-high).
  - Sampled 1 behaves exactly like lock loss: same next-edge output clear, FSM to WAIT_LOCK.
  - The sequence restarts once iSOFT_RESET=0 and lock_s=1.
- Not defined: port absent; only lock loss and inRESET restart the sequence.

## Test plan

- Power-up, P_CHANNELS=4, P_LOCK_STABLE=256, P_STAGGER=16: raise iPLL_LOCK at cycle 10 → oRESET_N[0..3] rise at cycles 268/284/300/316; oSYSTEM_READY rises at 316.
- Glitch: lock low for 1 cycle at STABLE count 200 → count restarts; oRESET_N[0] is delayed by a full 256 cycles after lock_s re-rises.
- Dividers: D={0,1,4,255} → oCLKEN periods of 1, 2, 5 and 256 cycles. Changing iCH_DIV in RUN has no effect.
- Lock loss in RUN: drop iPLL_LOCK → all outputs 0 three cycles later. Re-raising lock repeats the full sequence.
- Async reset at cycle 290, mid-RELEASE → all outputs 0 without a clock edge; the sequence restarts after inRESET deasserts.
- With CLOCK_RESET_SEQ_SOFT_RESET_EN: 1-cycle iSOFT_RESET pulse in RUN → outputs clear on the next edge; release resumes P_LOCK_STABLE cycles later.
